// File: rtl/scope_pkg.sv
// Shared types for the scope capture path: FSM states, channel-select encodings
// and the sample selector used by the capture scheduler.
package scope_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic [1:0] CH_I     = 2'd0;
  localparam logic [1:0] CH_Q     = 2'd1;
  localparam logic [1:0] CH_MAG   = 2'd2;
  localparam logic [1:0] CH_I_ALT = 2'd3;

  // |I|+|Q| is formed at 10 bits so that |-128| = 128 survives before saturating to 127.
  function automatic logic signed [SAMPLE_W-1:0] select_sample(
    input logic [1:0]                 ch,
    input logic signed [SAMPLE_W-1:0] i_s,
    input logic signed [SAMPLE_W-1:0] q_s
  );
    logic [SAMPLE_W:0]   abs_i;
    logic [SAMPLE_W:0]   abs_q;
    logic [SAMPLE_W+1:0] mag;
    abs_i = i_s[SAMPLE_W-1] ? (~{1'b1, i_s}) + 9'd1 : {1'b0, i_s};
    abs_q = q_s[SAMPLE_W-1] ? (~{1'b1, q_s}) + 9'd1 : {1'b0, q_s};
    mag   = {1'b0, abs_i} + {1'b0, abs_q};
    case (ch)
      CH_Q:    return q_s;
      CH_MAG:  return (mag > 10'd127) ? 8'sd127 : $signed(mag[SAMPLE_W-1:0]);
      default: return i_s;
    endcase
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the asynchronous VGA vsync into the clk domain and emits a one-cycle
// pulse on its falling edge.
module vsync_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic fall_o
);

  // Stages 0/1 are the synchroniser, stage 2 holds the previous synchronised value.
  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], vsync_i};
    end
  end

  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/capture_scheduler.sv
// Decimates the IFFT I/Q stream, triggers on level/slope (or timeout), fills one
// bank of the ping-pong scope RAM and swaps banks on the next VGA frame edge.
module capture_scheduler
  import scope_pkg::*;
#(
  parameter  int DEPTH        = 64,
  parameter  int DECIM        = 31,
  parameter  int TRIG_TIMEOUT = 1024,
  localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       CLOCK_50,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       single,
  input  logic [1:0]                 ch_sel,
  input  logic                       trig_en,
  input  logic signed [SAMPLE_W-1:0] trig_level,
  input  logic                       trig_slope,
  input  logic signed [SAMPLE_W-1:0] ifft_Iout,
  input  logic signed [SAMPLE_W-1:0] ifft_Qout,
  input  logic                       sample_valid,
  input  logic                       Vsyn,
  output logic                       wr_en,
  output logic                       wr_bank,
  output logic [AW-1:0]              wr_addr,
  output logic [SAMPLE_W-1:0]        wr_data,
  output logic                       rd_bank,
  output logic                       busy,
  output logic                       triggered,
  output logic                       frame_ready,
  output logic                       overrun
);

  localparam int DW = $clog2(DECIM + 1);
  localparam int TW = $clog2(TRIG_TIMEOUT + 1);

  state_e                      state_q, state_d;
  logic [DW-1:0]               decim_q, decim_d;
  logic [TW-1:0]               to_q, to_d;
  logic [AW-1:0]               cnt_q, cnt_d;
  logic signed [SAMPLE_W-1:0]  prev_q, prev_d;
  logic                        wr_en_q, wr_en_d;
  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [AW-1:0]               wr_addr_q, wr_addr_d;
  logic signed [SAMPLE_W-1:0]  wr_data_q, wr_data_d;
  logic                        frame_ready_q, frame_ready_d;
  logic                        overrun_q, overrun_d;

  logic                        frame_edge;
  logic                        accept;
  logic                        trig;
  logic signed [SAMPLE_W-1:0]  sel;

  vsync_edge_sync u_vsync (
    .clk     (CLOCK_50),
    .rst_n   (rst_n),
    .vsync_i (Vsyn),
    .fall_o  (frame_edge)
  );

  assign sel    = select_sample(ch_sel, ifft_Iout, ifft_Qout);
  assign accept = sample_valid && (decim_q == '0) && (state_q != ST_IDLE);

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    decim_d       = decim_q;
    to_d          = to_q;
    cnt_d         = cnt_q;
    prev_d        = prev_q;
    wr_en_d       = 1'b0;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_ready_d = 1'b0;
    overrun_d     = overrun_q;
    trig          = 1'b0;

    if (state_q == ST_IDLE) begin
      decim_d = '0;
    end else if (sample_valid) begin
      decim_d = (decim_q == DW'(DECIM - 1)) ? '0 : decim_q + DW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (single || run) begin
          state_d = ST_ARMED;
          to_d    = '0;
        end
      end
      ST_ARMED: begin
        if (accept) begin
          prev_d = sel;
          if (!trig_en || (to_q == TW'(TRIG_TIMEOUT - 1))) begin
            trig = 1'b1;
          end else if (!trig_slope) begin
            trig = (prev_q < trig_level) && (sel >= trig_level);
          end else begin
            trig = (prev_q > trig_level) && (sel <= trig_level);
          end
          to_d = to_q + TW'(1);
          if (trig) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = sel;
            cnt_d     = AW'(1);
            state_d   = (DEPTH == 1) ? ST_DONE : ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = sel;
          cnt_d     = cnt_q + AW'(1);
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (frame_edge) begin
          rd_bank_d     = wr_bank_q;
          wr_bank_d     = ~wr_bank_q;
          frame_ready_d = 1'b1;
          wr_addr_d     = '0;
          to_d          = '0;
          state_d       = run ? ST_ARMED : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A frame edge outside DONE means the display re-shows a stale bank.
    if (frame_edge && (state_q != ST_DONE) && run) begin
      overrun_d = 1'b1;
    end
    if (single) begin
      overrun_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      decim_q       <= '0;
      to_q          <= '0;
      cnt_q         <= '0;
      prev_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      decim_q       <= decim_d;
      to_q          <= to_d;
      cnt_q         <= cnt_d;
      prev_q        <= prev_d;
      wr_en_q       <= wr_en_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_bank     = wr_bank_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_bank     = rd_bank_q;
  assign frame_ready = frame_ready_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);
  assign triggered   = (state_q == ST_CAPTURE) || (state_q == ST_DONE);

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed bench for capture_scheduler: expected RAM writes are queued as stimulus
// is issued and a monitor pops and compares them whenever wr_en is seen.
module tb_capture_scheduler;
  import scope_pkg::*;

  localparam int DEPTH = 64;
  localparam int DECIM = 4;
  localparam int TO    = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              single = 1'b0;
  logic [1:0]        ch_sel = CH_I;
  logic              trig_en = 1'b0;
  logic signed [7:0] trig_level = '0;
  logic              trig_slope = 1'b0;
  logic signed [7:0] i_s = '0;
  logic signed [7:0] q_s = '0;
  logic              sample_valid = 1'b0;
  logic              vsyn = 1'b1;

  logic              wr_en, wr_bank, rd_bank, busy, triggered, frame_ready, overrun;
  logic [5:0]        wr_addr;
  logic [7:0]        wr_data;

  typedef struct packed {
    logic       bank;
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  capture_scheduler #(.DEPTH(DEPTH), .DECIM(DECIM), .TRIG_TIMEOUT(TO)) dut (
    .CLOCK_50     (clk),
    .rst_n        (rst_n),
    .run          (run),
    .single       (single),
    .ch_sel       (ch_sel),
    .trig_en      (trig_en),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .ifft_Iout    (i_s),
    .ifft_Qout    (q_s),
    .sample_valid (sample_valid),
    .Vsyn         (vsyn),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_bank      (rd_bank),
    .busy         (busy),
    .triggered    (triggered),
    .frame_ready  (frame_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic b, input logic [5:0] a, input logic [7:0] d);
    wr_t e;
    e.bank = b;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decimation group: the first valid of each group is the accepted one.
  task automatic send(input logic [7:0] i, input logic [7:0] q);
    for (int k = 0; k < DECIM; k++) begin
      sample_valid = 1'b1;
      i_s = i;
      q_s = q;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic pulse_single();
    single = 1'b1;
    tick();
    single = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic vsync_glitch();
    vsyn = 1'b0;
    repeat (5) tick();
    vsyn = 1'b1;
    repeat (5) tick();
  endtask

  task automatic wait_frame();
    int hi;
    hi = 0;
    vsyn = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (frame_ready === 1'b1) hi++;
    end
    check("frame_ready_pulse_cycles", hi, 1);
    vsyn = 1'b1;
    repeat (5) tick();
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got bank %0d addr %0d data 0x%0h, expected no write",
                   wr_bank, wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("write_bank_addr_data", {17'd0, wr_bank, wr_addr, wr_data}, {17'd0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_rd_bank", rd_bank, 1);
    check("rst_overrun", overrun, 0);
    check("rst_triggered", triggered, 0);
    check("rst_frame_ready", frame_ready, 0);

    // Reset mid-capture
    trig_en = 1'b0;
    ch_sel  = CH_I;
    pulse_single();
    push(0, 0, 8'd7);  send(8'd7, 8'd0);
    push(0, 1, 8'd8);  send(8'd8, 8'd0);
    push(0, 2, 8'd9);  send(8'd9, 8'd0);
    check("t1_triggered", triggered, 1);
    do_reset();
    check("t1_busy", busy, 0);
    check("t1_wr_en", wr_en, 0);
    check("t1_wr_bank", wr_bank, 0);
    check("t1_rd_bank", rd_bank, 1);
    check("t1_overrun", overrun, 0);

    // Decimated Q ramp fills bank 0, then swap on frame edge
    ch_sel = CH_Q;
    pulse_single();
    for (int q = 0; q < 256; q++) begin
      if (q % DECIM == 0) push(0, 6'(q / DECIM), 8'(q));
      sample_valid = 1'b1;
      i_s = '0;
      q_s = 8'(q);
      tick();
    end
    sample_valid = 1'b0;
    check("t2_done_triggered", triggered, 1);
    check("t2_done_busy", busy, 1);
    repeat (4) tick();
    wait_frame();
    check("t2_rd_bank", rd_bank, 0);
    check("t2_wr_bank", wr_bank, 1);
    check("t2_idle_after_swap", busy, 0);

    // Rising trigger: 5, 9 no; 12 fires
    ch_sel     = CH_I;
    trig_en    = 1'b1;
    trig_level = 8'sd10;
    trig_slope = 1'b0;
    pulse_single();
    send(8'd5, 8'd0);
    send(8'd9, 8'd0);
    check("t3_rise_not_yet", triggered, 0);
    push(1, 0, 8'd12); send(8'd12, 8'd0);
    check("t3_rise_fired", triggered, 1);
    push(1, 1, 8'd20); send(8'd20, 8'd0);
    do_reset();

    // Falling trigger: 12 no; 10 fires
    trig_slope = 1'b1;
    pulse_single();
    send(8'd12, 8'd0);
    check("t3_fall_not_yet", triggered, 0);
    push(0, 0, 8'd10); send(8'd10, 8'd0);
    check("t3_fall_fired", triggered, 1);
    do_reset();

    // Timeout on flat input
    trig_slope = 1'b0;
    trig_level = 8'sd50;
    pulse_single();
    repeat (TO - 1) send(8'd0, 8'd0);
    check("t4_before_timeout", triggered, 0);
    push(0, 0, 8'd0); send(8'd0, 8'd0);
    check("t4_timeout_fired", triggered, 1);
    do_reset();

    // Level -128 rising only fires through the timeout
    trig_level = -8'sd128;
    pulse_single();
    for (int k = 0; k < TO - 1; k++) send((k % 2 == 0) ? 8'h80 : 8'h7f, 8'd0);
    check("t4_min_level_not_fired", triggered, 0);
    push(0, 0, 8'h7f); send(8'h7f, 8'd0);
    check("t4_min_level_timeout", triggered, 1);
    do_reset();

    // Magnitude channel with saturation
    trig_en = 1'b0;
    ch_sel  = CH_MAG;
    pulse_single();
    push(0, 0, 8'd127); send(8'h80, 8'h80);
    push(0, 1, 8'd7);   send(8'hfd, 8'h04);
    push(0, 2, 8'd120); send(8'd100, 8'd20);
    push(0, 3, 8'd127); send(8'h9c, 8'h9c);
    push(0, 4, 8'd127); send(8'h80, 8'h00);
    push(0, 5, 8'd0);   send(8'h00, 8'h00);
    do_reset();

    // Continuous run: overrun set by frame edges in CAPTURE, cleared by single; banks alternate
    ch_sel = CH_I;
    run    = 1'b1;
    tick();
    check("t6_armed_busy", busy, 1);
    push(0, 0, 8'd3); send(8'd3, 8'd0);
    vsync_glitch();
    vsync_glitch();
    check("t6_overrun_set", overrun, 1);
    pulse_single();
    check("t6_overrun_cleared", overrun, 0);
    check("t6_still_capturing", triggered, 1);
    for (int k = 1; k < DEPTH; k++) begin
      push(0, 6'(k), 8'(k * 5 + 3));
      send(8'(k * 5 + 3), 8'd0);
    end
    check("t6_done_a", triggered, 1);
    wait_frame();
    check("t6_rd_bank_a", rd_bank, 0);
    check("t6_wr_bank_a", wr_bank, 1);
    check("t6_rearmed", busy, 1);
    check("t6_rearmed_not_trig", triggered, 0);
    check("t6_no_overrun", overrun, 0);
    for (int k = 0; k < DEPTH; k++) begin
      push(1, 6'(k), 8'(k + 100));
      send(8'(k + 100), 8'd0);
    end
    wait_frame();
    check("t6_rd_bank_b", rd_bank, 1);
    check("t6_wr_bank_b", wr_bank, 0);
    run = 1'b0;
    repeat (4) tick();

    check("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
